// File: rtl/tdm_mux_8to1_seq.sv
// Sequential 8:1 TDM serialiser: captures 8 channels, emits one per slot on y with slot index s.
// Optional parity output p when TDM_MUX_PARITY_EN is defined.
module tdm_mux_8to1_seq #(
    parameter int WIDTH       = 1,
    parameter int SLOT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               load,
    input  logic [8*WIDTH-1:0] i,
    output logic [WIDTH-1:0]   y,
    output logic [2:0]         s,
    output logic               y_valid,
    output logic               frame_start,
    output logic               busy
`ifdef TDM_MUX_PARITY_EN
    ,
    output logic               p
`endif
);

    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state, state_nx;
    logic [8*WIDTH-1:0] frame, frame_nx;
    logic [CW-1:0]      cnt, cnt_nx;
    logic [WIDTH-1:0]   y_nx;
    logic [2:0]         s_nx, s_inc;
    logic               y_valid_nx, frame_start_nx, busy_nx;
    logic               capture;
`ifdef TDM_MUX_PARITY_EN
    logic               p_nx;
`endif

    assign s_inc = s + 3'd1;

    always_comb begin
        state_nx       = state;
        frame_nx       = frame;
        cnt_nx         = cnt;
        y_nx           = y;
        s_nx           = s;
        y_valid_nx     = y_valid;
        busy_nx        = busy;
        frame_start_nx = 1'b0;
        capture        = 1'b0;
`ifdef TDM_MUX_PARITY_EN
        p_nx           = p;
`endif
        case (state)
            IDLE: begin
                if (load) begin
                    capture = 1'b1;
                end else begin
                    y_valid_nx = 1'b0;
                    busy_nx    = 1'b0;
                end
            end
            SEND: begin
                if (cnt != CNT_LAST) begin
                    cnt_nx = cnt + 1'b1;
                end else if (s != 3'd7) begin
                    s_nx   = s_inc;
                    y_nx   = frame[int'(s_inc)*WIDTH +: WIDTH];
                    cnt_nx = '0;
                end else if (load) begin
                    // last cycle of the frame: back-to-back recapture, no idle gap
                    capture = 1'b1;
                end else begin
                    state_nx   = IDLE;
                    y_valid_nx = 1'b0;
                    busy_nx    = 1'b0;
                    cnt_nx     = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (capture) begin
            state_nx       = SEND;
            frame_nx       = i;
            cnt_nx         = '0;
            s_nx           = 3'd0;
            y_nx           = i[WIDTH-1:0];
            y_valid_nx     = 1'b1;
            busy_nx        = 1'b1;
            frame_start_nx = 1'b1;
`ifdef TDM_MUX_PARITY_EN
            p_nx           = ^i;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            frame       <= '0;
            cnt         <= '0;
            y           <= '0;
            s           <= '0;
            y_valid     <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
`ifdef TDM_MUX_PARITY_EN
            p           <= 1'b0;
`endif
        end else if (en) begin
            state       <= state_nx;
            frame       <= frame_nx;
            cnt         <= cnt_nx;
            y           <= y_nx;
            s           <= s_nx;
            y_valid     <= y_valid_nx;
            frame_start <= frame_start_nx;
            busy        <= busy_nx;
`ifdef TDM_MUX_PARITY_EN
            p           <= p_nx;
`endif
        end
    end

endmodule

// File: tb/tb_tdm_mux_8to1_seq.sv
// Bench for tdm_mux_8to1_seq: vector table for frame sequencing, hand sequences for hold/abort,
// a loopback DMUX over random frames, and parity checks when TDM_MUX_PARITY_EN is defined.
module tb_tdm_mux_8to1_seq;

    typedef struct {
        logic       rst;
        logic       load;
        logic [7:0] i;
        logic       y;
        logic [2:0] s;
        logic       v;
        logic       fs;
        logic       b;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, en, load;
    logic [7:0] i;
    logic [0:0] y;
    logic [2:0] s;
    logic       yv, fs, busy;
    logic       rst3, en3, load3;
    logic [7:0] i3;
    logic [0:0] y3;
    logic [2:0] s3;
    logic       yv3, fs3, busy3;
`ifdef TDM_MUX_PARITY_EN
    logic       p, p3;
`endif

    int n_cmp = 0;
    int n_err = 0;
    vec_t tv[$];
    logic [7:0] dmux;

    always #5 clk = ~clk;

    tdm_mux_8to1_seq #(.WIDTH(1), .SLOT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .load(load), .i(i),
        .y(y), .s(s), .y_valid(yv), .frame_start(fs), .busy(busy)
`ifdef TDM_MUX_PARITY_EN
        , .p(p)
`endif
    );

    tdm_mux_8to1_seq #(.WIDTH(1), .SLOT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst3), .en(en3), .load(load3), .i(i3),
        .y(y3), .s(s3), .y_valid(yv3), .frame_start(fs3), .busy(busy3)
`ifdef TDM_MUX_PARITY_EN
        , .p(p3)
`endif
    );

    // receive-side 1:8 demux used for the loopback check
    always_comb begin
        dmux = '0;
        if (yv) dmux[s] = y[0];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic addv(input logic r, input logic l, input logic [7:0] d, input logic ey,
                        input logic [2:0] es, input logic ev, input logic efs, input logic eb);
        vec_t v;
        v.rst = r; v.load = l; v.i = d; v.y = ey; v.s = es; v.v = ev; v.fs = efs; v.b = eb;
        tv.push_back(v);
    endtask

    initial begin
        logic [7:0] fa, cur, nxt;
        int bb;
        fa = 8'hA6;
        rst = 1'b1; en = 1'b1; load = 1'b0; i = '0;
        rst3 = 1'b1; en3 = 1'b1; load3 = 1'b0; i3 = '0;

        // basic frame
        addv(1, 0, 8'h00, 0, 0, 0, 0, 0);
        addv(1, 0, 8'h00, 0, 0, 0, 0, 0);
        addv(0, 1, fa,    fa[0], 0, 1, 1, 1);
        for (int k = 1; k < 8; k++) addv(0, 0, fa, fa[k], 3'(k), 1, 0, 1);
        addv(0, 0, 8'h00, 1, 7, 0, 0, 0);
        addv(0, 0, 8'h00, 1, 7, 0, 0, 0);
        // back-to-back: FF then 00 captured on the s=7 cycle
        addv(0, 1, 8'hFF, 1, 0, 1, 1, 1);
        for (int k = 1; k < 8; k++) addv(0, 0, 8'h00, 1, 3'(k), 1, 0, 1);
        addv(0, 1, 8'h00, 0, 0, 1, 1, 1);
        for (int k = 1; k < 8; k++) addv(0, 0, 8'hFF, 0, 3'(k), 1, 0, 1);
        addv(0, 0, 8'h00, 0, 7, 0, 0, 0);
        // ignored mid-frame load with changed i
        addv(0, 1, fa,    fa[0], 0, 1, 1, 1);
        addv(0, 0, 8'h00, fa[1], 1, 1, 0, 1);
        addv(0, 0, 8'h00, fa[2], 2, 1, 0, 1);
        addv(0, 0, 8'h00, fa[3], 3, 1, 0, 1);
        addv(0, 1, 8'h00, fa[4], 4, 1, 0, 1);
        addv(0, 1, 8'h00, fa[5], 5, 1, 0, 1);
        addv(0, 0, 8'h00, fa[6], 6, 1, 0, 1);
        addv(0, 0, 8'h00, fa[7], 7, 1, 0, 1);
        addv(0, 0, 8'h00, fa[7], 7, 0, 0, 0);

        for (int n = 0; n < tv.size(); n++) begin
            rst = tv[n].rst; load = tv[n].load; i = tv[n].i;
            tick();
            chk($sformatf("v%0d.y", n),  32'(y),    32'(tv[n].y));
            chk($sformatf("v%0d.s", n),  32'(s),    32'(tv[n].s));
            chk($sformatf("v%0d.yv", n), 32'(yv),   32'(tv[n].v));
            chk($sformatf("v%0d.fs", n), 32'(fs),   32'(tv[n].fs));
            chk($sformatf("v%0d.b", n),  32'(busy), 32'(tv[n].b));
        end
        load = 1'b0;

        // SLOT_CYCLES=3 with a 5-cycle hold at s=2
        rst3 = 1'b1; tick();
        rst3 = 1'b0; load3 = 1'b1; i3 = fa; tick();
        chk("h.k0.s", 32'(s3), 0); chk("h.k0.y", 32'(y3), 32'(fa[0]));
        chk("h.k0.fs", 32'(fs3), 1); chk("h.k0.yv", 32'(yv3), 1);
        load3 = 1'b0; i3 = 8'h00;
        for (int k = 1; k < 24; k++) begin
            if (k == 7) begin
                en3 = 1'b0;
                for (int h = 0; h < 5; h++) begin
                    tick();
                    chk("hold.s", 32'(s3), 2); chk("hold.y", 32'(y3), 32'(fa[2]));
                    chk("hold.yv", 32'(yv3), 1);
                end
                en3 = 1'b1;
            end
            tick();
            chk($sformatf("h.k%0d.s", k), 32'(s3), 32'(k / 3));
            chk($sformatf("h.k%0d.y", k), 32'(y3), 32'(fa[k / 3]));
            chk($sformatf("h.k%0d.fs", k), 32'(fs3), 0);
            chk($sformatf("h.k%0d.b", k), 32'(busy3), 1);
        end
        tick();
        chk("h.end.yv", 32'(yv3), 0); chk("h.end.b", 32'(busy3), 0); chk("h.end.s", 32'(s3), 7);

        // frozen frame_start pulse, then abort at s=5 (rst with en low)
        load3 = 1'b1; i3 = 8'hFF; tick();
        load3 = 1'b0; en3 = 1'b0;
        tick(); chk("frz.fs", 32'(fs3), 1);
        tick(); chk("frz.fs2", 32'(fs3), 1);
        en3 = 1'b1;
        for (int k = 1; k < 16; k++) tick();
        chk("ab.pre.s", 32'(s3), 5); chk("ab.pre.y", 32'(y3), 1); chk("ab.pre.fs", 32'(fs3), 0);
        rst3 = 1'b1; en3 = 1'b0; tick();
        chk("ab.y", 32'(y3), 0); chk("ab.s", 32'(s3), 0); chk("ab.yv", 32'(yv3), 0);
        chk("ab.fs", 32'(fs3), 0); chk("ab.b", 32'(busy3), 0);
        rst3 = 1'b0; en3 = 1'b1; tick();
        chk("ab.idle.yv", 32'(yv3), 0); chk("ab.idle.s", 32'(s3), 0);

        // loopback through the demux, random frames, mixed gaps
        cur = 8'($urandom); load = 1'b1; i = cur; tick();
        for (int f = 0; f < 100; f++) begin
            nxt = 8'($urandom);
            bb = int'($urandom_range(0, 1));
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("lb.f%0d.s", f), 32'(s), 32'(k));
                chk($sformatf("lb.f%0d.ch%0d", f, k), 32'(dmux[k]), 32'(cur[k]));
                if (k == 7 && bb == 1 && f < 99) begin
                    load = 1'b1; i = nxt;
                end else begin
                    load = 1'b0; i = 8'($urandom);
                end
                tick();
            end
            if (bb == 0 && f < 99) begin
                chk($sformatf("lb.f%0d.gap", f), 32'(yv), 0);
                load = 1'b1; i = nxt; tick();
            end
            cur = nxt;
        end
        load = 1'b0; tick();
        chk("lb.end.yv", 32'(yv), 0);

`ifdef TDM_MUX_PARITY_EN
        load = 1'b1; i = 8'b0000_0111; tick();
        load = 1'b0; i = 8'h00;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("par7.k%0d", k), 32'(p), 1);
            tick();
        end
        chk("par.idle", 32'(p), 1);
        load = 1'b1; i = 8'b0000_0011; tick();
        chk("par3", 32'(p), 0);
        load = 1'b0; for (int k = 0; k < 8; k++) tick();
        load = 1'b1; i = 8'b0000_0111; tick();
        chk("par7b", 32'(p), 1);
        load = 1'b0; rst = 1'b1; tick();
        chk("par.rst", 32'(p), 0);
        rst = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
